// File: rtl/fp_align_pkg.sv
// rtl/fp_align_pkg.sv - floating-point format type shared by the alignment scheduler
package fp_align_pkg;

    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;

endpackage

// File: rtl/fp_align_sched.sv
// rtl/fp_align_sched.sv - two-requester arbiter in front of a shared alignment barrel shifter
// Grants one op per cycle, drives the external shifter and registers its result.
module fp_align_sched
    import fp_align_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  fp_fmt_e     req0_fmt,
    input  logic [23:0] req0_frac,
    input  logic [15:0] req0_ediff,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  fp_fmt_e     req1_fmt,
    input  logic [23:0] req1_frac,
    input  logic [15:0] req1_ediff,

    output fp_fmt_e     sh_fmt,
    output logic [23:0] sh_x,
    output logic [7:0]  sh_s,
    input  logic [25:0] sh_r,
    input  logic        sh_sticky_h,
    input  logic        sh_sticky_l,

    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output fp_fmt_e     out_fmt,
    output logic [25:0] out_r,
    output logic        out_sticky_h,
    output logic        out_sticky_l,
    output logic [15:0] op_count
);

    logic        out_valid_q, out_valid_d;
    logic        out_id_q, out_id_d;
    fp_fmt_e     out_fmt_q, out_fmt_d;
    logic [25:0] out_r_q, out_r_d;
    logic        out_sticky_h_q, out_sticky_h_d;
    logic        out_sticky_l_q, out_sticky_l_d;
    logic [15:0] op_count_q, op_count_d;
    logic        last_grant_q, last_grant_d;

    logic        any_valid;
    logic        grant_id;
    logic        accept;
    fp_fmt_e     g_fmt;
    logic [23:0] g_frac;
    logic [15:0] g_ediff;

    function automatic logic [3:0] sat4(input logic [7:0] e);
        return (e > 8'd15) ? 4'hF : e[3:0];
    endfunction

    function automatic logic [4:0] sat5(input logic [7:0] e);
        return (e > 8'd31) ? 5'h1F : e[4:0];
    endfunction

    // Ready never looks at the payload, only at valids, output occupancy and history.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            grant_id = ~req0_valid;
        end
        accept     = rst_n & any_valid & (~out_valid_q | out_ready);
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
    end

    always_comb begin
        g_fmt   = grant_id ? req1_fmt   : req0_fmt;
        g_frac  = grant_id ? req1_frac  : req0_frac;
        g_ediff = grant_id ? req1_ediff : req0_ediff;

        sh_fmt = FP32;
        sh_x   = '0;
        sh_s   = '0;
        if (any_valid) begin
            sh_fmt = g_fmt;
            if (g_fmt == FP16) begin
                // Middle byte zeroed so hi-lane bits cannot leak into the lo lane.
                sh_x = {g_frac[23:16], 8'h00, g_frac[7:0]};
                sh_s = {sat4(g_ediff[15:8]), sat4(g_ediff[7:0])};
            end else begin
                sh_x = g_frac;
                sh_s = {3'b000, sat5(g_ediff[7:0])};
            end
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_fmt_d      = out_fmt_q;
        out_r_d        = out_r_q;
        out_sticky_h_d = out_sticky_h_q;
        out_sticky_l_d = out_sticky_l_q;
        op_count_d     = op_count_q;
        last_grant_d   = last_grant_q;
        if (accept) begin
            out_valid_d    = 1'b1;
            out_id_d       = grant_id;
            out_fmt_d      = g_fmt;
            out_r_d        = sh_r;
            out_sticky_h_d = sh_sticky_h;
            out_sticky_l_d = sh_sticky_l;
            op_count_d     = op_count_q + 16'd1;
            last_grant_d   = grant_id;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // last_grant resets to 1 so req0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_id_q       <= 1'b0;
            out_fmt_q      <= FP32;
            out_r_q        <= '0;
            out_sticky_h_q <= 1'b0;
            out_sticky_l_q <= 1'b0;
            op_count_q     <= '0;
            last_grant_q   <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_fmt_q      <= out_fmt_d;
            out_r_q        <= out_r_d;
            out_sticky_h_q <= out_sticky_h_d;
            out_sticky_l_q <= out_sticky_l_d;
            op_count_q     <= op_count_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_fmt      = out_fmt_q;
    assign out_r        = out_r_q;
    assign out_sticky_h = out_sticky_h_q;
    assign out_sticky_l = out_sticky_l_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_fp_align_sched.sv
// tb/tb_fp_align_sched.sv - self-checking bench for fp_align_sched
module tb_fp_align_sched;
    import fp_align_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    fp_fmt_e     req0_fmt, req1_fmt, sh_fmt, out_fmt;
    logic [23:0] req0_frac, req1_frac, sh_x;
    logic [15:0] req0_ediff, req1_ediff, op_count;
    logic [7:0]  sh_s;
    logic [25:0] sh_r, out_r;
    logic        sh_sticky_h, sh_sticky_l;
    logic        out_valid, out_ready, out_id, out_sticky_h, out_sticky_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_align_sched #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fmt(req0_fmt),
        .req0_frac(req0_frac), .req0_ediff(req0_ediff),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fmt(req1_fmt),
        .req1_frac(req1_frac), .req1_ediff(req1_ediff),
        .sh_fmt(sh_fmt), .sh_x(sh_x), .sh_s(sh_s),
        .sh_r(sh_r), .sh_sticky_h(sh_sticky_h), .sh_sticky_l(sh_sticky_l),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_fmt(out_fmt),
        .out_r(out_r), .out_sticky_h(out_sticky_h), .out_sticky_l(out_sticky_l),
        .op_count(op_count)
    );

    // Right shift of a value extended by two guard bits; returns {sticky, result}.
    function automatic logic [26:0] lane(input longint unsigned v, input int s);
        longint unsigned ext, kept;
        ext  = v * 4;
        kept = ext >> s;
        return {(ext != (kept << s)), kept[25:0]};
    endfunction

    // External shared shifter.
    logic [26:0] env_h, env_l;
    always_comb begin
        env_h       = lane(64'(sh_x[23:16]), int'(sh_s[7:4]));
        env_l       = lane(64'(sh_x[7:0]), int'(sh_s[3:0]));
        sh_r        = {env_h[9:0], 6'b0, env_l[9:0]};
        sh_sticky_h = env_h[26];
        sh_sticky_l = env_l[26];
        if (sh_fmt == FP32) begin
            env_l       = lane(64'(sh_x), int'(sh_s[4:0]));
            sh_r        = env_l[25:0];
            sh_sticky_h = 1'b0;
            sh_sticky_l = env_l[26];
        end
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] ref_s(input fp_fmt_e f, input logic [15:0] ed);
        int hi, lo;
        hi = int'(ed[15:8]);
        lo = int'(ed[7:0]);
        if (f == FP32) return 8'(imin(lo, 31));
        return 8'(imin(hi, 15) * 16 + imin(lo, 15));
    endfunction

    // Returns {sticky_h, sticky_l, r} expected for an op.
    function automatic logic [27:0] ref_result(input fp_fmt_e f, input logic [23:0] frac,
                                               input logic [15:0] ed);
        logic [26:0] h, l;
        if (f == FP32) begin
            l = lane(64'(frac), imin(int'(ed[7:0]), 31));
            return {1'b0, l[26], l[25:0]};
        end
        h = lane(64'(frac[23:16]), imin(int'(ed[15:8]), 15));
        l = lane(64'(frac[7:0]), imin(int'(ed[7:0]), 15));
        return {h[26], l[26], h[9:0], 6'b0, l[9:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        fp_fmt_e     fmt;
        logic [23:0] frac;
        logic [15:0] ediff;
        logic [7:0]  s;
        logic [23:0] x;
        logic [25:0] r;
        logic        sth;
        logic        stl;
    } vec_t;

    vec_t vecs[8];

    logic [25:0] snap_r;
    logic        snap_id;
    logic        mv, mid, msh, msl, mlast, acc, gid;
    fp_fmt_e     mfmt, gfmt;
    logic [25:0] mr;
    logic [15:0] mcount, ged;
    logic [23:0] gfrac;
    logic [27:0] res;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{FP32, 24'h800000, 16'd3,        8'h03, 24'h800000, 26'h0400000, 1'b0, 1'b0};
        vecs[1] = '{FP32, 24'hFFFFFF, 16'd40,       8'h1F, 24'hFFFFFF, 26'h0000000, 1'b0, 1'b1};
        vecs[2] = '{FP16, 24'hFFAA81, {8'd20, 8'd1}, 8'hF1, 24'hFF0081, 26'h0000102, 1'b1, 1'b0};
        vecs[3] = '{FP32, 24'h123456, 16'd0,        8'h00, 24'h123456, 26'h048D158, 1'b0, 1'b0};
        vecs[4] = '{FP32, 24'h000001, 16'd31,       8'h1F, 24'h000001, 26'h0000000, 1'b0, 1'b1};
        vecs[5] = '{FP32, 24'h800000, 16'd25,       8'h19, 24'h800000, 26'h0000001, 1'b0, 1'b0};
        vecs[6] = '{FP16, 24'h805501, {8'd15, 8'd2}, 8'hF2, 24'h800001, 26'h0000001, 1'b1, 1'b0};
        vecs[7] = '{FP16, 24'h403C03, {8'd1, 8'd3},  8'h13, 24'h400003, 26'h0800001, 1'b0, 1'b1};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_fmt = FP32; req1_fmt = FP32;
        req0_frac = 24'h0; req1_frac = 24'h0; req0_ediff = 16'h0; req1_ediff = 16'h0;
        tick();
        tick();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_sticky", 32'({out_sticky_h, out_sticky_l}), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_fmt", 32'(out_fmt), 32'(FP32));
        chk("rst_op_count", 32'(op_count), 32'd0);

        // Round-robin contention straight out of reset.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'(k % 2 == 0));
            chk("rr_ready1", 32'(req1_ready), 32'(k % 2 == 1));
            if (k > 0) chk("rr_out_id", 32'(out_id), 32'((k - 1) % 2));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rr_op_count", 32'(op_count), 32'd4);
        chk("rr_last_id", 32'(out_id), 32'd1);
        tick();

        // Directed vectors through requester 0.
        for (int i = 0; i < 8; i++) begin
            req0_fmt = vecs[i].fmt; req0_frac = vecs[i].frac; req0_ediff = vecs[i].ediff;
            req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'd1);
            chk($sformatf("vec%0d_sh_s", i), 32'(sh_s), 32'(vecs[i].s));
            chk($sformatf("vec%0d_sh_x", i), 32'(sh_x), 32'(vecs[i].x));
            chk($sformatf("vec%0d_sh_fmt", i), 32'(sh_fmt), 32'(vecs[i].fmt));
            tick();
            req0_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_out_r", i), 32'(out_r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_sticky_h", i), 32'(out_sticky_h), 32'(vecs[i].sth));
            chk($sformatf("vec%0d_sticky_l", i), 32'(out_sticky_l), 32'(vecs[i].stl));
            chk($sformatf("vec%0d_out_id", i), 32'(out_id), 32'd0);
            chk($sformatf("vec%0d_out_fmt", i), 32'(out_fmt), 32'(vecs[i].fmt));
            tick();
        end
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("vec_op_count", 32'(op_count), 32'd12);
        chk("idle_sh_fmt", 32'(sh_fmt), 32'(FP32));
        chk("idle_sh_s", 32'(sh_s), 32'd0);

        // Back-pressure: last grant was req0, so req1 loads first.
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_frac = 24'h0F0F0F; req1_frac = 24'hC00000; req1_ediff = 16'd1;
        #1;
        chk("bp_load_ready1", 32'(req1_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        snap_r = out_r; snap_id = out_id;
        chk("bp_load_r", 32'(snap_r), 32'h1800000);
        for (int k = 0; k < 3; k++) begin
            req0_frac = 24'($urandom); req1_frac = 24'($urandom);
            req1_ediff = 16'($urandom);
            #1;
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_r", 32'(out_r), 32'(snap_r));
            chk("bp_out_id", 32'(out_id), 32'(snap_id));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rel_ready0", 32'(req0_ready), 32'(k % 2 == 0));
            chk("bp_rel_ready1", 32'(req1_ready), 32'(k % 2 == 1));
            tick();
        end

        // Reset while a result is held.
        out_ready = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        chk("mid_rst_ready0", 32'(req0_ready), 32'd1);
        chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
        tick();

        // Randomized traffic against the reference model.
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mv = 1'b0; mid = 1'b0; mfmt = FP32; mr = '0; msh = 1'b0; msl = 1'b0;
        mlast = 1'b1; mcount = 16'd0;
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom % 4) != 0;
            req1_valid = ($urandom % 3) != 0;
            req0_fmt   = fp_fmt_e'($urandom % 2);
            req1_fmt   = fp_fmt_e'($urandom % 2);
            req0_frac  = 24'($urandom);
            req1_frac  = 24'($urandom);
            req0_ediff = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))};
            req1_ediff = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))};
            out_ready  = ($urandom % 3) != 0;
            #1;
            if (req0_valid && req1_valid) gid = ~mlast;
            else gid = req1_valid;
            acc   = (req0_valid || req1_valid) && (!mv || out_ready);
            gfmt  = gid ? req1_fmt : req0_fmt;
            gfrac = gid ? req1_frac : req0_frac;
            ged   = gid ? req1_ediff : req0_ediff;
            chk("rnd_ready0", 32'(req0_ready), 32'(acc && !gid));
            chk("rnd_ready1", 32'(req1_ready), 32'(acc && gid));
            chk("rnd_out_valid", 32'(out_valid), 32'(mv));
            chk("rnd_op_count", 32'(op_count), 32'(mcount));
            if (mv) begin
                chk("rnd_out_id", 32'(out_id), 32'(mid));
                chk("rnd_out_fmt", 32'(out_fmt), 32'(mfmt));
                chk("rnd_out_r", 32'(out_r), 32'(mr));
                chk("rnd_sticky", 32'({out_sticky_h, out_sticky_l}), 32'({msh, msl}));
            end
            if (req0_valid || req1_valid) begin
                chk("rnd_sh_s", 32'(sh_s), 32'(ref_s(gfmt, ged)));
                chk("rnd_sh_x", 32'(sh_x), 32'((gfmt == FP16) ? (gfrac & 24'hFF00FF) : gfrac));
            end
            if (acc) begin
                res = ref_result(gfmt, gfrac, ged);
                mv = 1'b1; mid = gid; mfmt = gfmt;
                msh = res[27]; msl = res[26]; mr = res[25:0];
                mcount = mcount + 16'd1;
                mlast = gid;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
